// File: rtl/axi_design_pkg.sv
// Shared descriptor layout, AXI constants and FSM
// state type for the address-issue block.
package axi_design_pkg;

  localparam int DESC_W      = 78;
  localparam int DESC_ADDR_L = 0;
  localparam int DESC_ADDR_W = 64;
  localparam int DESC_BC_L   = 64;
  localparam int DESC_BC_W   = 12;
  localparam int DESC_WR_BIT = 76;
  localparam int DESC_RD_BIT = 77;

  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // up to (7 + 4095 + 7) >> 3 = 513 beats
  localparam int REM_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CALC,
    ISSUE
  } state_e;

  function automatic logic [8:0] clamp_beats(
    input logic [REM_W-1:0] rem,
    input logic [8:0]       maxb
  );
    return (rem > {1'b0, maxb}) ? maxb : rem[8:0];
  endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Combinational burst arithmetic: total beats of a
// descriptor, current/next burst size and next address.
module axi_burst_calc
  import axi_design_pkg::*;
#(
  parameter int MAX_BEATS  = 16,
  parameter int DATA_BYTES = 8
) (
  input  logic [2:0]       addr_lo_i,
  input  logic [11:0]      bcnt_i,
  input  logic [63:0]      addr_i,
  input  logic [REM_W-1:0] rem_i,
  output logic [REM_W-1:0] total_o,
  output logic [7:0]       first_len_o,
  output logic [REM_W-1:0] rem_left_o,
  output logic [7:0]       next_len_o,
  output logic [63:0]      next_addr_o,
  output logic             last_o
);

  localparam logic [8:0] MAXB = 9'(MAX_BEATS);

  logic [12:0] sum;
  logic [8:0]  first_b;
  logic [8:0]  cur_b;
  logic [8:0]  nxt_b;

  assign sum     = 13'(addr_lo_i) + 13'(bcnt_i) + 13'd7;
  assign total_o = sum[12:3];

  assign first_b     = clamp_beats(total_o, MAXB);
  assign first_len_o = 8'(first_b - 9'd1);

  assign cur_b      = clamp_beats(rem_i, MAXB);
  assign rem_left_o = rem_i - {1'b0, cur_b};
  assign last_o     = (rem_left_o == '0);

  assign nxt_b      = clamp_beats(rem_left_o, MAXB);
  assign next_len_o = 8'(nxt_b - 9'd1);

  // later bursts start beat-aligned
  assign next_addr_o = {addr_i[63:3], 3'b000}
                     + 64'(cur_b) * 64'(DATA_BYTES);

endmodule

// File: rtl/axi_addr_issue.sv
// Pops transfer descriptors and issues them as a
// sequence of AXI AR or AW INCR bursts.
module axi_addr_issue
  import axi_design_pkg::*;
#(
  parameter int MAX_BEATS  = 16,
  parameter int DATA_BYTES = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ram4k_empty,
  output logic              ram4k_rd,
  input  logic [DESC_W-1:0] ram4k_rddata,
  output logic [63:0]       araddr,
  output logic [63:0]       awaddr,
  output logic [7:0]        arlen,
  output logic [7:0]        awlen,
  output logic [2:0]        arsize,
  output logic [2:0]        awsize,
  output logic [1:0]        arburst,
  output logic [1:0]        awburst,
  output logic              arvalid,
  input  logic              arready,
  output logic              awvalid,
  input  logic              awready,
  output logic              desc_done,
  output logic              desc_err
);

  state_e           state_q;
  logic             rd_q;
  logic [63:0]      d_addr_q;
  logic [11:0]      d_bc_q;
  logic             d_wr_q;
  logic             d_rd_q;
  logic [63:0]      addr_q;
  logic [7:0]       len_q;
  logic [REM_W-1:0] rem_q;
  logic             arvalid_q;
  logic             awvalid_q;
  logic             done_q;
  logic             err_q;

  logic [REM_W-1:0] total;
  logic [7:0]       first_len;
  logic [REM_W-1:0] rem_left;
  logic [7:0]       next_len;
  logic [63:0]      next_addr;
  logic             last;
  logic             hs;
  logic             drop;
  logic             bad_dir;

  axi_burst_calc #(
    .MAX_BEATS (MAX_BEATS),
    .DATA_BYTES(DATA_BYTES)
  ) u_calc (
    .addr_lo_i  (d_addr_q[2:0]),
    .bcnt_i     (d_bc_q),
    .addr_i     (addr_q),
    .rem_i      (rem_q),
    .total_o    (total),
    .first_len_o(first_len),
    .rem_left_o (rem_left),
    .next_len_o (next_len),
    .next_addr_o(next_addr),
    .last_o     (last)
  );

  assign hs      = (arvalid_q & arready)
                 | (awvalid_q & awready);
  assign bad_dir = (d_rd_q == d_wr_q);
  assign drop    = bad_dir | (d_bc_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      d_addr_q  <= '0;
      d_bc_q    <= '0;
      d_wr_q    <= 1'b0;
      d_rd_q    <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!ram4k_empty) begin
            rd_q    <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          // data is valid the cycle after the pop
          if (!rd_q) begin
            d_addr_q <= ram4k_rddata[DESC_ADDR_L +: DESC_ADDR_W];
            d_bc_q   <= ram4k_rddata[DESC_BC_L +: DESC_BC_W];
            d_wr_q   <= ram4k_rddata[DESC_WR_BIT];
            d_rd_q   <= ram4k_rddata[DESC_RD_BIT];
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (drop) begin
            done_q  <= 1'b1;
            err_q   <= bad_dir;
            state_q <= IDLE;
          end else begin
            addr_q    <= d_addr_q;
            len_q     <= first_len;
            rem_q     <= total;
            arvalid_q <= d_rd_q;
            awvalid_q <= d_wr_q;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (hs) begin
            if (last) begin
              arvalid_q <= 1'b0;
              awvalid_q <= 1'b0;
              rem_q     <= '0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              addr_q <= next_addr;
              len_q  <= next_len;
              rem_q  <= rem_left;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram4k_rd  = rd_q;
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign arlen     = len_q;
  assign awlen     = len_q;
  assign arsize    = AXI_SIZE_8B;
  assign awsize    = AXI_SIZE_8B;
  assign arburst   = AXI_BURST_INCR;
  assign awburst   = AXI_BURST_INCR;
  assign arvalid   = arvalid_q;
  assign awvalid   = awvalid_q;
  assign desc_done = done_q;
  assign desc_err  = err_q;

endmodule

// File: tb/tb_axi_addr_issue.sv
// Scoreboard bench for axi_addr_issue: descriptors are
// expanded into expected bursts by a behavioural model.
module tb_axi_addr_issue;

  localparam int MAXB = 16;

  typedef struct {
    bit          rd;
    logic [63:0] a;
    logic [7:0]  l;
    bit          last;
  } burst_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ram4k_empty;
  logic        ram4k_rd;
  logic [77:0] ram4k_rddata = '0;
  logic [63:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, awvalid;
  logic        arready = 1'b0;
  logic        awready = 1'b0;
  logic        desc_done, desc_err;

  axi_addr_issue #(.MAX_BEATS(MAXB), .DATA_BYTES(8)) dut (
    .clk(clk), .resetn(resetn),
    .ram4k_empty(ram4k_empty), .ram4k_rd(ram4k_rd),
    .ram4k_rddata(ram4k_rddata),
    .araddr(araddr), .awaddr(awaddr),
    .arlen(arlen), .awlen(awlen),
    .arsize(arsize), .awsize(awsize),
    .arburst(arburst), .awburst(awburst),
    .arvalid(arvalid), .arready(arready),
    .awvalid(awvalid), .awready(awready),
    .desc_done(desc_done), .desc_err(desc_err)
  );

  always #5 clk = ~clk;

  // descriptor store model
  logic [77:0] mem [0:1023];
  int wp = 0;
  int rp = 0;
  assign ram4k_empty = (wp == rp);

  always @(posedge clk) begin
    if (ram4k_rd) begin
      #1;
      ram4k_rddata = mem[rp % 1024];
      rp = rp + 1;
    end
  end

  // ready driver: 0 tied high, 1 random, 2 low
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    if (rmode == 0) begin
      arready = 1'b1;
      awready = 1'b1;
    end else if (rmode == 1) begin
      arready = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
    end else begin
      arready = 1'b0;
      awready = 1'b0;
    end
  end

  burst_t exp_b[$];
  bit     exp_d[$];
  int     drain_tok = 0;
  bit     quiet = 1'b0;

  task automatic push_desc(input logic [63:0] a,
                           input int bc,
                           input bit wr,
                           input bit rd);
    burst_t      b;
    int          rem;
    int          n;
    logic [63:0] cur;
    mem[wp % 1024] = {rd, wr, 12'(bc), a};
    if (bc == 0 || rd == wr) begin
      exp_d.push_back(rd == wr);
    end else begin
      rem = (int'(a[2:0]) + bc + 7) / 8;
      cur = a;
      while (rem > 0) begin
        n = (rem < MAXB) ? rem : MAXB;
        b.rd = rd;
        b.a = cur;
        b.l = 8'(n - 1);
        b.last = (rem == n);
        exp_b.push_back(b);
        rem = rem - n;
        cur = (cur & ~64'd7) + 64'(n * 8);
      end
      exp_d.push_back(1'b0);
    end
    wp = wp + 1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_b.size() == 0 && exp_d.size() == 0
          && wp == rp)
        break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    drain_tok = drain_tok + 1;
    repeat (2) @(negedge clk);
  endtask

  // monitor / scoreboard
  int     checks = 0;
  int     errors = 0;
  int     drain_seen = 0;
  bit     hold_v = 1'b0;
  bit     done_due = 1'b0;
  burst_t held;
  burst_t cur;
  burst_t e;
  bit     rdy;
  bit     dexp;

  always @(negedge clk) begin
    if (!resetn) begin
      checks++;
      if (arvalid || awvalid || ram4k_rd || desc_done
          || desc_err || araddr != 0 || awaddr != 0
          || arlen != 0 || awlen != 0
          || arsize != 3 || arburst != 1) begin
        errors++;
        $display("FAIL reset_state: arv=%0d awv=%0d rd=%0d done=%0d err=%0d ara=%h awa=%h arl=%0d awl=%0d sz=%0d bu=%0d, want all 0 sz=3 bu=1",
                 arvalid, awvalid, ram4k_rd, desc_done,
                 desc_err, araddr, awaddr, arlen, awlen,
                 arsize, arburst);
      end
      exp_b.delete();
      exp_d.delete();
      hold_v = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        checks++;
        if (!desc_done) begin
          errors++;
          $display("FAIL done_latency: desc_done=0, want 1 one cycle after last handshake");
        end
      end
      done_due = 1'b0;
      if (quiet) begin
        checks++;
        if (arvalid || awvalid || ram4k_rd) begin
          errors++;
          $display("FAIL quiet: arv=%0d awv=%0d rd=%0d, want 0 0 0",
                   arvalid, awvalid, ram4k_rd);
        end
      end
      if (ram4k_rd) begin
        checks++;
        if (ram4k_empty) begin
          errors++;
          $display("FAIL pop_empty: rd=1 empty=1, want no pop");
        end
      end
      if (arvalid || awvalid) begin
        checks++;
        if (arvalid && awvalid) begin
          errors++;
          $display("FAIL both_valid: arv=1 awv=1, want one");
        end
        cur.rd = arvalid;
        cur.a = arvalid ? araddr : awaddr;
        cur.l = arvalid ? arlen : awlen;
        cur.last = 1'b0;
        rdy = arvalid ? arready : awready;
        if (hold_v) begin
          checks++;
          if (cur.rd != held.rd || cur.a != held.a
              || cur.l != held.l) begin
            errors++;
            $display("FAIL stable: got rd=%0d a=%h l=%0d, want rd=%0d a=%h l=%0d",
                     cur.rd, cur.a, cur.l,
                     held.rd, held.a, held.l);
          end
        end
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: rd=%0d a=%h l=%0d, want no valid",
                   cur.rd, cur.a, cur.l);
        end else begin
          e = exp_b[0];
          checks++;
          if (cur.rd != e.rd || cur.a != e.a || cur.l != e.l
              || (cur.rd ? arsize : awsize) != 3'd3
              || (cur.rd ? arburst : awburst) != 2'b01) begin
            errors++;
            $display("FAIL burst: got rd=%0d a=%h l=%0d, want rd=%0d a=%h l=%0d",
                     cur.rd, cur.a, cur.l, e.rd, e.a, e.l);
          end
          if (rdy) begin
            void'(exp_b.pop_front());
            done_due = e.last;
          end
        end
        hold_v = !rdy;
        held = cur;
      end else if (hold_v) begin
        checks++;
        errors++;
        $display("FAIL valid_dropped: valid=0, want held until handshake");
        hold_v = 1'b0;
      end
      if (desc_done) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=1 err=%0d, want none",
                   desc_err);
        end else begin
          dexp = exp_d.pop_front();
          if (desc_err != dexp) begin
            errors++;
            $display("FAIL desc_err: got %0d, want %0d",
                     desc_err, dexp);
          end
        end
      end else if (desc_err) begin
        checks++;
        errors++;
        $display("FAIL err_alone: err=1 done=0, want err only with done");
      end
      if (drain_tok != drain_seen) begin
        drain_seen = drain_tok;
        checks++;
        if (exp_b.size() != 0 || exp_d.size() != 0) begin
          errors++;
          $display("FAIL drain: bursts left=%0d dones left=%0d, want 0 0",
                   exp_b.size(), exp_d.size());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] ra;
  int          rbc;
  int          sel;
  int          k;
  bit          rwr;
  bit          rrd;

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    rmode = 0;
    push_desc(64'h1000, 64, 1'b0, 1'b1);
    wait_drain();

    push_desc(64'h2FFC, 4, 1'b1, 1'b0);
    wait_drain();

    push_desc(64'h3003, 200, 1'b0, 1'b1);
    wait_drain();

    rmode = 2;
    push_desc(64'h5008, 64, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (awvalid) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    rmode = 0;
    wait_drain();

    push_desc(64'h4000, 32, 1'b1, 1'b1);
    push_desc(64'h4100, 0, 1'b0, 1'b1);
    wait_drain();

    rmode = 1;
    for (int d = 0; d < 40; d++) begin
      ra = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) rbc = 0;
      else if (sel == 1) rbc = $urandom_range(0, 4095);
      else rbc = $urandom_range(1, 300);
      k = $urandom_range(0, 5);
      rwr = (k == 0) || (k >= 4);
      rrd = (k == 0) || (k == 2) || (k == 3);
      push_desc(ra, rbc, rwr, rrd);
      if (d % 8 == 7) wait_drain();
    end
    wait_drain();

    // reset in the middle of the second burst
    rmode = 2;
    push_desc(64'h3003, 200, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arvalid) break;
    end
    rmode = 0;
    @(negedge clk);
    rmode = 2;
    @(negedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rmode = 0;
    quiet = 1'b1;
    repeat (20) @(negedge clk);
    quiet = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
